// File: rtl/regfile_wb_arbiter_if.sv
// Register-file write-port bundle shared by the pipeline writeback and the long-latency unit.
// Latency: none. This file only groups the wires.
// Backpressure: wb_stall_o holds the pipeline; lu_valid_i/lu_ready_o form the long-latency handshake.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            wb_valid_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            wb_stall_o;
    logic            lu_valid_i;
    logic [4:0]      lu_rd_i;
    logic [XLEN-1:0] lu_data_i;
    logic            lu_ready_o;
    logic            iss_valid_i;
    logic [4:0]      iss_rd_i;
    logic [31:0]     busy_o;
    logic            init_busy_o;
    logic            rf_wr_en_o;
    logic [4:0]      rf_rd_idx_o;
    logic [XLEN-1:0] rf_wr_data_o;

    // Arbiter side
    modport slave (
        input  wb_valid_i, wb_rd_i, wb_data_i,
        input  lu_valid_i, lu_rd_i, lu_data_i,
        input  iss_valid_i, iss_rd_i,
        output wb_stall_o, lu_ready_o, busy_o, init_busy_o,
        output rf_wr_en_o, rf_rd_idx_o, rf_wr_data_o
    );

    // Core / register-file side
    modport master (
        output wb_valid_i, wb_rd_i, wb_data_i,
        output lu_valid_i, lu_rd_i, lu_data_i,
        output iss_valid_i, iss_rd_i,
        input  wb_stall_o, lu_ready_o, busy_o, init_busy_o,
        input  rf_wr_en_o, rf_rd_idx_o, rf_wr_data_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and a long-latency unit, with busy scoreboard.
// Latency: zero cycles. The port is driven combinationally and the write lands on the following negedge.
// Backpressure: lu is denied while wb writes, and after STARVE_LIMIT denials wb is stalled one cycle. Macro REGFILE_CLEAR_EN adds post-reset zeroing of x1..x31.
module regfile_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    regfile_wb_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

`ifdef REGFILE_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0] state_q, state_d;
    logic [4:0] clr_idx_q, clr_idx_d;
`endif

    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic [31:0]     busy_q, busy_d;

    logic            wr_en;
    logic [4:0]      wr_idx;
    logic [XLEN-1:0] wr_data;
    logic            lu_ready;
    logic            wb_stall;
    logic            init_busy;
    logic            wb_req;
    logic            starve;

    // Port ownership, handshake outputs and next-state computation
    always_comb begin
        wr_en        = 1'b0;
        wr_idx       = 5'd0;
        wr_data      = '0;
        lu_ready     = 1'b0;
        wb_stall     = 1'b0;
        init_busy    = 1'b0;
        starve_cnt_d = starve_cnt_q;
        busy_d       = busy_q;
`ifdef REGFILE_CLEAR_EN
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
`endif
        wb_req = bus.wb_valid_i && (bus.wb_rd_i != 5'd0);
        starve = (starve_cnt_q == LIMIT) && bus.lu_valid_i;

        if (rst_i) begin
            init_busy    = 1'b1;
            starve_cnt_d = 4'd0;
            busy_d       = '0;
`ifdef REGFILE_CLEAR_EN
            state_d      = ST_CLEAR;
            clr_idx_d    = 5'd1;
        end else if (state_q == ST_CLEAR) begin
            // Zero one register per cycle; requesters are ignored meanwhile
            wr_en     = 1'b1;
            wr_idx    = clr_idx_q;
            wr_data   = '0;
            init_busy = 1'b1;
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) begin
                state_d = ST_RUN;
            end
`endif
        end else begin
            if (starve) begin
                // lu has waited long enough: it takes the port, wb re-presents next cycle
                wb_stall     = 1'b1;
                lu_ready     = 1'b1;
                wr_en        = (bus.lu_rd_i != 5'd0);
                wr_idx       = bus.lu_rd_i;
                wr_data      = bus.lu_data_i;
                starve_cnt_d = 4'd0;
            end else if (wb_req) begin
                wr_en   = 1'b1;
                wr_idx  = bus.wb_rd_i;
                wr_data = bus.wb_data_i;
                if (bus.lu_valid_i) begin
                    starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
                end else begin
                    starve_cnt_d = 4'd0;
                end
            end else begin
                // Port is free for lu; rd=0 is accepted without a write
                lu_ready     = 1'b1;
                wr_en        = bus.lu_valid_i && (bus.lu_rd_i != 5'd0);
                wr_idx       = bus.lu_rd_i;
                wr_data      = bus.lu_data_i;
                starve_cnt_d = 4'd0;
            end

            // Retire clears first, so a same-cycle reissue of that index leaves it busy
            if (bus.lu_valid_i && lu_ready) begin
                busy_d[bus.lu_rd_i] = 1'b0;
            end
            if (bus.iss_valid_i) begin
                busy_d[bus.iss_rd_i] = 1'b1;
            end
            busy_d[0] = 1'b0;
        end
    end

    // State registers with synchronous reset folded into the next-state logic
    always_ff @(posedge clk_i) begin
        starve_cnt_q <= starve_cnt_d;
        busy_q       <= busy_d;
`ifdef REGFILE_CLEAR_EN
        state_q      <= state_d;
        clr_idx_q    <= clr_idx_d;
`endif
    end

    assign bus.rf_wr_en_o   = wr_en;
    assign bus.rf_rd_idx_o  = wr_idx;
    assign bus.rf_wr_data_o = wr_data;
    assign bus.lu_ready_o   = lu_ready;
    assign bus.wb_stall_o   = wb_stall;
    assign bus.init_busy_o  = init_busy;
    assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by randomized traffic against a port-ownership model.
// Latency: outputs sampled 4 time units after each posedge, before the negedge write.
// Backpressure: the model tracks lu denials and the busy set independently of the design.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 64;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Shadow register file, written the way the real one is: on negedge
    logic [XLEN-1:0] rf_m [32];
    always @(negedge clk) begin
        if (bus.rf_wr_en_o === 1'b1) rf_m[bus.rf_rd_idx_o] <= bus.rf_wr_data_o;
    end

    // Reference model state: how many cycles lu has been refused, and which regs are pending
    int          denied;
    logic [31:0] busy_m;

    logic            o_en, o_rdy, o_stall;
    logic [4:0]      o_idx;
    logic [XLEN-1:0] o_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit wv, input logic [4:0] wr, input logic [63:0] wd,
                         input bit lv, input logic [4:0] lr, input logic [63:0] ld,
                         input bit iv, input logic [4:0] ir);
        bus.wb_valid_i  = wv;  bus.wb_rd_i  = wr; bus.wb_data_i = wd;
        bus.lu_valid_i  = lv;  bus.lu_rd_i  = lr; bus.lu_data_i = ld;
        bus.iss_valid_i = iv;  bus.iss_rd_i = ir;
    endtask

    // One RUN cycle: drive, predict who owns the port, compare, advance the model
    task automatic apply(input bit wv, input logic [4:0] wr, input logic [63:0] wd,
                         input bit lv, input logic [4:0] lr, input logic [63:0] ld,
                         input bit iv, input logic [4:0] ir);
        bit lu_forced, wb_owns, e_en;
        @(posedge clk); #1;
        drive(wv, wr, wd, lv, lr, ld, iv, ir);
        #3;
        lu_forced = lv && (denied >= LIMIT);
        wb_owns   = !lu_forced && wv && (wr != 0);
        e_en      = wb_owns || (lv && lr != 0);
        chk("init_busy", bus.init_busy_o, 0);
        chk("busy", bus.busy_o, busy_m);
        chk("lu_ready", bus.lu_ready_o, !wb_owns);
        chk("wb_stall", bus.wb_stall_o, lu_forced);
        chk("wr_en", bus.rf_wr_en_o, e_en);
        if (e_en) begin
            chk("wr_idx", bus.rf_rd_idx_o, wb_owns ? wr : lr);
            chk("wr_data", bus.rf_wr_data_o, wb_owns ? wd : ld);
        end
        o_en = bus.rf_wr_en_o; o_rdy = bus.lu_ready_o; o_stall = bus.wb_stall_o;
        o_idx = bus.rf_rd_idx_o; o_data = bus.rf_wr_data_o;
        denied = (wb_owns && lv) ? denied + 1 : 0;
        if (lv && !wb_owns) busy_m[lr] = 1'b0;
        if (iv && ir != 0)  busy_m[ir] = 1'b1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Hold reset one cycle with junk on the inputs; outputs must be quiet
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 5'd3, 64'h1, 1, 5'd4, 64'h2, 1, 5'd5);
        #3;
        chk("rst_wr_en", bus.rf_wr_en_o, 0);
        chk("rst_lu_ready", bus.lu_ready_o, 0);
        chk("rst_wb_stall", bus.wb_stall_o, 0);
        chk("rst_init_busy", bus.init_busy_o, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        denied = 0;
        busy_m = '0;
    endtask

`ifdef REGFILE_CLEAR_EN
    // Walk n clear cycles right after reset release (first sample is clear cycle 1)
    task automatic clear_walk(input int n);
        for (int k = 1; k <= n; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            drive(1, 5'd2, 64'h55, 1, 5'd6, 64'h66, 1, 5'(k));
            #3;
            chk("clr_en", bus.rf_wr_en_o, 1);
            chk("clr_idx", bus.rf_rd_idx_o, k);
            chk("clr_data", bus.rf_wr_data_o, 0);
            chk("clr_init_busy", bus.init_busy_o, 1);
            chk("clr_lu_ready", bus.lu_ready_o, 0);
            chk("clr_busy", bus.busy_o, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
`endif

    task automatic full_reset();
        do_reset();
`ifdef REGFILE_CLEAR_EN
        clear_walk(31);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d1, d2;
        for (int i = 0; i < 32; i++) rf_m[i] = 'x;
        rf_m[0] = '0;
        denied = 0;
        busy_m = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        full_reset();
        idle();

`ifdef REGFILE_CLEAR_EN
        // Preload xN=N, reset, and confirm the clear sequence zeroes everything
        for (int n = 1; n < 32; n++) apply(1, 5'(n), 64'(n), 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("preload_x17", rf_m[17], 17);
        do_reset();
        clear_walk(10);
        do_reset();
        clear_walk(31);
        idle();
        @(negedge clk); #1;
        for (int n = 1; n < 32; n++) chk("cleared_xn", rf_m[n], 0);
`endif

        // wb and lu collide: wb wins, lu goes next cycle
        d1 = 64'hA5A5_0000_1111_2222;
        d2 = 64'h0707_0707_0707_0707;
        apply(1, 5'd5, d1, 1, 5'd7, d2, 0, 0);
        chk("coll_rdy0", o_rdy, 0);
        chk("coll_idx5", o_idx, 5);
        apply(0, 0, 0, 1, 5'd7, d2, 0, 0);
        chk("coll_rdy1", o_rdy, 1);
        chk("coll_idx7", o_idx, 7);
        #2;
        chk("coll_x5", rf_m[5], d1);
        chk("coll_x7", rf_m[7], d2);

        // Starvation: four denials, then lu forces its way in
        idle();
        for (int c = 1; c <= 4; c++) begin
            apply(1, 5'd3, 64'(c), 1, 5'd9, 64'h99, 0, 0);
            chk("starve_deny", o_rdy, 0);
        end
        apply(1, 5'd3, 64'h5, 1, 5'd9, 64'h99, 0, 0);
        chk("starve_stall", o_stall, 1);
        chk("starve_rdy", o_rdy, 1);
        chk("starve_idx9", o_idx, 9);
        apply(1, 5'd3, 64'h5, 0, 0, 0, 0, 0);
        chk("starve_wb_resume", o_idx, 3);
        chk("starve_wb_en", o_en, 1);

        // Scoreboard: set, clear+set same cycle, clear
        idle();
        apply(0, 0, 0, 0, 0, 0, 1, 5'd12);
        apply(0, 0, 0, 1, 5'd12, 64'hC, 1, 5'd12);
        chk("sb_set", bus.busy_o, 32'h1000);
        apply(0, 0, 0, 1, 5'd12, 64'hC, 0, 0);
        chk("sb_keep", bus.busy_o, 32'h1000);
        idle();
        chk("sb_clear", bus.busy_o, 32'h0);

        // x0 handling on both requesters
        apply(1, 5'd0, 64'hDEAD, 1, 5'd4, 64'h44, 1, 5'd0);
        chk("x0_rdy", o_rdy, 1);
        chk("x0_idx4", o_idx, 4);
        #2;
        chk("x0_x4", rf_m[4], 64'h44);
        chk("x0_x0", rf_m[0], 0);
        apply(0, 0, 0, 1, 5'd0, 64'hBEEF, 0, 0);
        chk("lu_rd0_rdy", o_rdy, 1);
        chk("lu_rd0_en", o_en, 0);
        idle();
        chk("x0_never_busy", bus.busy_o, 0);

        // Reset while busy bits are pending drops them
        apply(0, 0, 0, 0, 0, 0, 1, 5'd20);
        full_reset();
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                full_reset();
            end else begin
                apply($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), {$urandom, $urandom},
                      $urandom_range(0, 2) == 0, 5'($urandom_range(0, 15)));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 31x64 integer register file. The register file writes on negedge, so this block drives the port combinationally within the cycle.
- Shares the port between two requesters:
  - the in-order pipeline writeback, which has priority and no backpressure;
  - a long-latency unit (mul/div/load) using a valid/ready handshake.
- Tracks outstanding long-latency destinations in a busy scoreboard.
- Optionally runs a post-reset sequence that zeroes x1..x31.

Parameters:
XLEN, 64, data width of register file write port
STARVE_LIMIT, 4, consecutive cycles the long-latency unit may be denied before the pipeline is stalled (1..15)

Ports:
clk_i  input  1  clock, posedge for all state in this block
rst_i  input  1  synchronous active-high reset
wb_valid_i  input  1  pipeline writeback request
wb_rd_i  input  5  pipeline destination index
wb_data_i  input  XLEN  pipeline write data
wb_stall_o  output  1  hold pipeline writeback stage this cycle (request is re-presented next cycle)
lu_valid_i  input  1  long-latency result valid
lu_rd_i  input  5  long-latency destination index
lu_data_i  input  XLEN  long-latency result data
lu_ready_o  output  1  long-latency result accepted this cycle
iss_valid_i  input  1  long-latency op issued
iss_rd_i  input  5  destination of issued op
busy_o  output  32  scoreboard; bit n = xn pending, bit 0 always 0
init_busy_o  output  1  clear sequence active; core must not issue or retire
rf_wr_en_o  output  1  register file write strobe
rf_rd_idx_o  output  5  register file destination index
rf_wr_data_o  output  XLEN  register file write data

Behaviour:
- All state registers on posedge clk_i. Reset is synchronous.
- Reset values: state=CLEAR (RUN without macro), clr_idx=1, busy=0, starve_cnt=0.
- While rst_i=1, outputs are: rf_wr_en_o=0, lu_ready_o=0, wb_stall_o=0, init_busy_o=1.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle drive rf_wr_en_o=1, rf_rd_idx_o=clr_idx, rf_wr_data_o=0, then clr_idx++.
  - After the cycle writing index 31, go to RUN. Exactly 31 write cycles.
  - init_busy_o=1, lu_ready_o=0, wb_stall_o=0. wb/lu/iss inputs are ignored.
- RUN (init_busy_o=0):
  - wb_req = wb_valid_i && wb_rd_i!=0. lu_valid with lu_rd_i==0 is a no-write request.
  - starve = (starve_cnt==STARVE_LIMIT) && lu_valid_i.
  - If starve:
    - wb_stall_o=1, lu_ready_o=1.
    - Port carries lu write (rf_wr_en_o = lu_rd_i!=0).
    - starve_cnt<=0.
  - Else if wb_req:
    - Port carries wb write.
    - lu_ready_o=0.
    - starve_cnt increments (saturating at STARVE_LIMIT) if lu_valid_i, else clears to 0.
  - Else:
    - lu_ready_o=1.
    - Port carries lu write if lu_valid_i && lu_rd_i!=0, otherwise rf_wr_en_o=0.
    - starve_cnt<=0.
  - Outputs are combinational from inputs and state, with zero-cycle latency. The write lands on the following negedge.
- Scoreboard:
  - lu accept (lu_valid_i && lu_ready_o) clears busy[lu_rd_i].
  - iss_valid_i sets busy[iss_rd_i].
  - Same index set and cleared in one cycle: the bit ends at 1 (clear then set).
  - Index 0 is never set.
  - Updates occur only in RUN; reset clears all bits.
- Reset mid-CLEAR restarts at clr_idx=1. Reset in RUN drops pending busy bits; the core must flush the long-latency unit.
- wb_stall_o is never asserted when lu_valid_i=0.

Optional Feature:
- Macro REGFILE_CLEAR_EN.
- Defined: the CLEAR state exists; after reset x1..x31 read 0 after 31 cycles.
- Undefined: reset goes directly to RUN, clr_idx logic is removed, init_busy_o=rst_i, and register contents after reset are undefined.

Test Plan:
- REGFILE_CLEAR_EN, preload xN=N via port, assert rst_i 1 cycle -> rf_wr_en_o=1 for exactly 31 cycles with idx 1..31 and data 0; init_busy_o falls on cycle 32; all xN read 0.
- RUN, wb_valid_i=1 wb_rd_i=5 and lu_valid_i=1 lu_rd_i=7 same cycle -> x5 written, lu_ready_o=0; next cycle wb idle -> lu_ready_o=1, x7 written.
- STARVE_LIMIT=4, wb_req with rd=3 every cycle, lu_valid_i held with rd=9 -> lu_ready_o=0 for cycles 1-4; cycle 5 wb_stall_o=1, lu_ready_o=1, x9 written; cycle 6 wb write to x3 proceeds.
- iss_valid_i rd=12 -> busy_o=0x1000 next cycle; lu accept rd=12 with iss_valid_i rd=12 same cycle -> busy_o stays 0x1000; lu accept alone -> busy_o=0.
- wb_valid_i rd=0 with lu_valid_i rd=4 -> lu_ready_o=1, x4 written, x0 reads 0; lu rd=0 accepted with rf_wr_en_o=0.
- rst_i pulsed at clear cycle 10 -> sequence restarts at idx 1, 31 full cycles follow; iss_valid_i during CLEAR leaves busy_o=0.
